// File: rtl/pipe_stage.sv
// pipe_stage: generic valid/ready pipeline register with flush and
// an optional two-entry skid buffer (PIPE_STAGE_SKID_EN).
//
// Parameters:
//   DATA_W    payload width in bits
//   RESET_VAL payload loaded on reset/flush and shown while empty
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop all held and incoming entries this cycle
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data payload
//   occupancy        held entries (0..2 with skid, 0..1 without)
// Build option:
//   PIPE_STAGE_SKID_EN  defined: skid register, registered in_ready
//                       undefined: single register, in_ready from
//                       out_ready combinationally
module pipe_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_valid_d;
  logic [DATA_W-1:0] w_main_data_d;

  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_skid_valid_d;
  logic [DATA_W-1:0] w_skid_data_d;

  // Ready comes straight from a flop, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready = !r_skid_valid;

  always_comb begin
    w_main_valid_d = r_main_valid;
    w_main_data_d  = r_main_data;
    w_skid_valid_d = r_skid_valid;
    w_skid_data_d  = r_skid_data;
    if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        // Older skid entry advances first to keep FIFO order.
        w_main_valid_d = 1'b1;
        w_main_data_d  = r_skid_data;
        w_skid_valid_d = w_in_fire;
        w_skid_data_d  = w_in_fire ? in_data : RESET_VAL;
      end else begin
        w_main_valid_d = w_in_fire;
        w_main_data_d  = w_in_fire ? in_data : RESET_VAL;
      end
    end else if (w_in_fire) begin
      w_skid_valid_d = 1'b1;
      w_skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
    end else begin
      r_skid_valid <= w_skid_valid_d;
      r_skid_data  <= w_skid_data_d;
    end
  end

  assign occupancy = r_skid_valid ? 2'd2
                                  : {1'b0, r_main_valid};

`else

  // Single slot: accept whenever the slot is empty or
  // is being drained in this same cycle.
  assign in_ready = !r_main_valid || out_ready;

  always_comb begin
    w_main_valid_d = r_main_valid;
    w_main_data_d  = r_main_data;
    if (w_in_fire) begin
      w_main_valid_d = 1'b1;
      w_main_data_d  = in_data;
    end else if (w_out_fire) begin
      w_main_valid_d = 1'b0;
      w_main_data_d  = RESET_VAL;
    end
  end

  assign occupancy = {1'b0, r_main_valid};

`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_main_data  <= w_main_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed bench for pipe_stage (32, 1, 97 bit
// instances); skid-specific steps follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

  localparam logic [31:0] RV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        w1_in = 1'b0;
  logic        w1_out;
  logic        w1_ir, w1_ov;
  logic [1:0]  w1_occ;
  logic [96:0] w97_in = '0;
  logic [96:0] w97_out;
  logic        w97_ir, w97_ov;
  logic [1:0]  w97_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(32), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage #(.DATA_W(1)) dut_w1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w1_ir),
    .in_data(w1_in), .out_valid(w1_ov),
    .out_ready(out_ready), .out_data(w1_out),
    .occupancy(w1_occ)
  );

  pipe_stage #(.DATA_W(97)) dut_w97 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w97_ir),
    .in_data(w97_in), .out_valid(w97_ov),
    .out_ready(out_ready), .out_data(w97_out),
    .occupancy(w97_occ)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ov"}, 128'(out_valid), 128'(0));
    chk({tag, "_od"}, 128'(out_data), 128'(RV));
    chk({tag, "_oc"}, 128'(occupancy), 128'(0));
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] d);
    chk({tag, "_ov"}, 128'(out_valid), 128'(1));
    chk({tag, "_od"}, 128'(out_data), 128'(d));
  endtask

  initial begin
    // reset with a pending input
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    out_ready = 1'b1;
    tick();
    chk_empty("rst0");
    tick();
    chk_empty("rst1");
    rst = 1'b0;
    #1;
    chk("rel_ir", 128'(in_ready), 128'(1));
    tick();
    chk_out("first", 32'hDEAD);
    chk("first_oc", 128'(occupancy), 128'(1));
    in_valid = 1'b0;
    tick();
    chk_empty("drain0");

    // streaming
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      #1;
      chk($sformatf("str_ir%0d", i),
          128'(in_ready), 128'(1));
      tick();
      chk_out($sformatf("str%0d", i), 32'(i));
      chk($sformatf("str_oc%0d", i),
          128'(occupancy), 128'(1));
    end
    in_valid = 1'b0;
    tick();
    chk_empty("drain1");

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk_out("bpA", 32'hA);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_ir1", 128'(in_ready), 128'(1));
    in_data = 32'hB;
    tick();
    chk_out("bpA2", 32'hA);
    chk("bp_oc2", 128'(occupancy), 128'(2));
    chk("bp_ir0", 128'(in_ready), 128'(0));
    in_data = 32'hC;
    tick();
    chk("bp_hold_oc", 128'(occupancy), 128'(2));
    chk_out("bp_hold", 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_out("bpB", 32'hB);
    chk("bpB_oc", 128'(occupancy), 128'(1));
    chk("bpB_ir", 128'(in_ready), 128'(1));
    tick();
    chk_empty("drain2");
`else
    in_data = 32'hC;
    #1;
    chk("bp_ir0", 128'(in_ready), 128'(0));
    tick();
    chk_out("bp_hold", 32'hA);
    chk("bp_hold_oc", 128'(occupancy), 128'(1));
    out_ready = 1'b1;
    #1;
    chk("bp_ir1", 128'(in_ready), 128'(1));
    tick();
    chk_out("bpC", 32'hC);
    chk("bpC_oc", 128'(occupancy), 128'(1));
    in_valid = 1'b0;
    tick();
    chk_empty("drain2");
`endif

    // flush drops held and incoming entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 32'h6;
    tick();
    chk("fl_pre_oc", 128'(occupancy), 128'(2));
`else
    chk("fl_pre_oc", 128'(occupancy), 128'(1));
`endif
    out_ready = 1'b1; flush = 1'b1; in_data = 32'h7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_leak%0d", i),
          128'(out_valid), 128'(0));
    end

    // reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h9;
    tick();
    chk_out("mid9", 32'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_empty("midrst");
    tick();
    chk("midrst_leak", 128'(out_valid), 128'(0));

    // width: walking ones through 97-bit and 1-bit stages
    for (int i = 0; i < 97; i++) begin
      in_valid = 1'b1;
      w97_in = 97'(1) << i;
      w1_in = 1'(i);
      tick();
      chk($sformatf("w97_%0d", i),
          128'(w97_out), 128'(97'(1) << i));
      if (i < 4) begin
        chk($sformatf("w1_%0d", i),
            128'(w1_out), 128'(i % 2));
        chk($sformatf("w1v_%0d", i),
            128'(w1_ov), 128'(1));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("w97_empty", 128'(w97_out), 128'(0));
    chk("w1_empty", 128'(w1_ov), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, flush, and an optional two-entry skid buffer. It is the generic replacement for the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in mina_cpu. It carries an opaque payload of configurable width, so stage-specific parameter structs are packed into the payload. It adds backpressure and flush behaviour that the fixed registers lack.

## Interface
Parameters:
- DATA_W, 32: payload width in bits (≥1).
- RESET_VAL, '0: payload value loaded on reset and flush (e.g. a packed NOP / MEM_OP_NONE encoding).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming entries this cycle.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  out  DATA_W  payload to downstream stage.
- occupancy  out  2  number of held entries (0..2; 0..1 without skid).

## Operation
- Reset values: out_valid=0, out_data=RESET_VAL, occupancy=0; in_ready=1 in the cycle after reset deasserts.
- Entries are FIFO-ordered. The main register drives out_data. The skid register holds the overflow entry.
- Per cycle, priority is rst > flush > normal.
- Flush: both entries are invalidated and their payloads set to RESET_VAL. An input handshaking in the same cycle is dropped. A downstream handshake in the flush cycle still counts as consumed from the downstream side; the flush outcome is the same.
- Normal operation, with skid:
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Main empty, or main consumed this cycle: the incoming entry, or the skid entry if held, moves to main. The skid entry moves first and the incoming entry goes to skid.
  - Main held, not consumed, input accepted: the input goes to skid.
  - Both full: in_ready=0 until main is consumed.
- Normal operation, without skid: in_ready = !out_valid || out_ready (combinational). There is a single entry and occupancy ≤1.
- Payloads are never modified. Bits pass through unchanged regardless of DATA_W.
- out_data is RESET_VAL whenever out_valid=0, so downstream logic may decode it unguarded.

## Timing
- Latency: 1 cycle from input handshake to out_valid when empty.
- Throughput: 1 entry/cycle sustained while out_ready=1, in both configurations.
- Skid mode: in_ready falls in the cycle after the skid register fills. At most one extra entry is absorbed after out_ready drops.
- Simultaneous in and out handshake at occupancy 1: occupancy stays 1 and main is replaced by the new entry.
- Simultaneous in and out handshake at occupancy 2 is impossible (in_ready=0).
- Rst or flush mid-stream: the state is empty on the next edge; no entry leaks out afterwards.
- in_valid may be asserted while in_ready=0. The data is held upstream; this is not an error.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer; in_ready driven from a flop; occupancy 0..2.
- PIPE_STAGE_SKID_EN undefined: single register; in_ready combinational from out_ready; occupancy bit 1 tied to 0. The skid register and its logic are not synthesised.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and in_data=0xDEAD. Required: out_valid=0, out_data=RESET_VAL, occupancy=0 throughout; first transfer one cycle after release.
- Streaming: feed 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1. Required: the same values appear on out_data in cycles 1..4 and in_ready stays 1.
- Backpressure (skid): out_ready=0 and send 0xA, then 0xB. Required: occupancy=2 and in_ready=0. Raise out_ready: output 0xA then 0xB, and in_ready returns to 1.
- Backpressure (no skid): out_ready=0 with 0xA held. Required: in_ready=0 in the same cycle, and 0xC is accepted only when out_ready=1.
- Flush: hold 0x5 and 0x6 (skid) and pulse flush while in_valid=1 with 0x7. Required: next cycle out_valid=0, out_data=RESET_VAL, occupancy=0; 0x7 never appears.
- Width: DATA_W=1 and DATA_W=97 builds with a walking-ones payload. Required: bit-exact pass-through.
